stream_demultiplexer: RTL
=========================

# stream_demultiplexer

Registered 1-to-4 stream demultiplexer: accepts one beat per cycle on a single valid/ready input and delivers it to one of four valid/ready sinks selected by a 2-bit address carried with the beat. It is the steering counterpart of the team's 4:1 multiplexer and sits between one producer and four consumers, for example a result bus fanning out to register-file write ports. A one-entry output register gives full throughput and breaks the combinational path from sink ready back to producer data.

## Interface
- WIDTH, default 8: data bits per beat.
- COUNT_WIDTH, default 8: per-channel delivered-beat counter width (only with DEMUX_COUNT_EN).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a beat.
- in_ready  output  1  block accepts the beat this cycle.
- in_data  input  WIDTH  beat payload.
- in_address  input  2  destination channel 0..3.
- out_valid  output  4  one-hot; bit k means the held beat is for sink k.
- out_ready  input  4  sink k can take its beat.
- out_data  output  WIDTH  held payload, shared by all sinks.
- count_sel  input  2  channel whose counter is read (DEMUX_COUNT_EN only).
- count_out  output  COUNT_WIDTH  delivered-beat count of channel count_sel (DEMUX_COUNT_EN only).

## Operation
- Holding register state: EMPTY or FULL, plus held_addr[1:0] and held_data[WIDTH-1:0].
- Accept: in_valid && in_ready. Deliver: FULL && out_ready[held_addr].
- in_ready = !reset && (EMPTY || out_ready[held_addr]).
- out_valid = FULL ? onehot(held_addr) : 4'b0000. out_data = held_data, all bits valid only while FULL.
- EMPTY, accept -> FULL; capture in_data and in_address.
- FULL, deliver without accept -> EMPTY.
- FULL, deliver with accept -> stay FULL; load the new beat in the same edge, so there is no bubble.
- FULL, no deliver -> hold. held_addr and held_data stay stable. in_ready = 0.
- out_ready bits of non-selected channels are ignored. They never cause delivery or affect in_ready.
- When out_valid[k] is high, it stays high and out_data stays stable until out_ready[k] is high.
- Reset: state EMPTY, held_addr 0, held_data 0, counters 0. A held beat is discarded. A beat offered during the reset cycle is not accepted.

## Timing
- Latency: a beat accepted at edge n is presented on out_valid and out_data from edge n to edge n+1. Minimum delay from input to sink is 1 cycle.
- Throughput: 1 beat per cycle when the destination sink holds out_ready high.
- in_ready is combinational from out_ready and state. The path is one decode plus one 4:1 select. No path exists from in_* to out_*.
- Reset outputs: out_valid 0000, out_data 0, in_ready 0 while reset is high and 1 in the cycle after, count_out 0.

## Configuration
- DEMUX_COUNT_EN defined: there are four COUNT_WIDTH counters. Counter k increments on each deliver to channel k and wraps from all-ones to 0. count_out = counter[count_sel], combinational. A deliver and a read in the same cycle show the pre-increment value.
- DEMUX_COUNT_EN undefined: the counters, count_sel and count_out are absent. Datapath behaviour is identical.

## Structure
- Package demux_pkg holds the following:
  - NUM_CHANNELS = 4 and ADDR_WIDTH = 2.
  - State enum with EMPTY = 1'b0 and FULL = 1'b1.
- Sub-module address_decoder: a combinational 2-to-4 one-hot decoder with an enable input. It is built from the team's gate macros (NOT/AND with #50 delays), to mirror the multiplexer's gate-level build. It is instantiated once for out_valid, enabled by FULL.
- Top level holds the holding register, state flop, the ready mux (out_ready[held_addr]), and the counters.

## Test plan
- Reset, then in_valid=1, in_address=2, in_data=8'hA5 with out_ready=4'b0100: out_valid=4'b0100 and out_data=A5 one cycle later, delivered on that edge, state EMPTY.
- Back-to-back beats to addresses 0,1,2,3 (data 10,11,12,13) with out_ready=4'b1111: one delivery per cycle, out_valid sequence 0001, 0010, 0100, 1000, and in_ready held at 1.
- Stall: held beat for channel 3 (data 3C), out_ready=4'b0111 for 5 cycles: out_valid stays 1000, data stays 3C, in_ready=0, and a new in_valid is not accepted. Raise out_ready[3]: delivery, and the waiting beat is accepted on that same edge.
- Reset while FULL (address 1, data 7E): out_valid becomes 0000 the next cycle, the beat is never delivered, and in_ready returns to 1 after reset drops.
- With DEMUX_COUNT_EN defined: deliver 258 beats to channel 2 with COUNT_WIDTH=8. count_sel=2 gives count_out=2 (wrapped), and the other channels read 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the 1-to-4 stream demultiplexer.
// The DEMUX_COUNT_EN build option is handled in stream_demultiplexer.sv.
package demux_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int ADDR_WIDTH   = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/address_decoder.sv
// 2-to-4 one-hot decoder with enable, built from NOT/AND gates
// to match the gate-level build of the companion multiplexer.
module address_decoder
  import demux_pkg::*;
(
  input  logic                    en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic [NUM_CHANNELS-1:0] onehot
);

  wire a0_n;
  wire a1_n;
  wire [NUM_CHANNELS-1:0] dec;

  not u_not0 (a0_n, addr[0]);
  not u_not1 (a1_n, addr[1]);

  and u_and0 (dec[0], en, a1_n,    a0_n);
  and u_and1 (dec[1], en, a1_n,    addr[0]);
  and u_and2 (dec[2], en, addr[1], a0_n);
  and u_and3 (dec[3], en, addr[1], addr[0]);

  assign onehot = dec;

endmodule

// File: rtl/stream_demultiplexer.sv
// Registered 1-to-4 valid/ready demultiplexer with a one-entry holding
// register; define DEMUX_COUNT_EN to add per-channel delivered-beat counters.
module stream_demultiplexer
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef DEMUX_COUNT_EN
  ,
  parameter int COUNT_WIDTH = 8
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [ADDR_WIDTH-1:0]   in_address,
  output logic [NUM_CHANNELS-1:0] out_valid,
  input  logic [NUM_CHANNELS-1:0] out_ready,
  output logic [WIDTH-1:0]        out_data
`ifdef DEMUX_COUNT_EN
  ,
  input  logic [ADDR_WIDTH-1:0]   count_sel,
  output logic [COUNT_WIDTH-1:0]  count_out
`endif
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        data_q, data_d;

  logic sel_ready;
  logic full;
  logic deliver;
  logic accept;

  // Only the ready of the channel holding the beat matters.
  assign sel_ready = out_ready[addr_q];
  assign full      = (state_q == FULL);
  assign deliver   = full && sel_ready;
  assign in_ready  = !reset && (!full || sel_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          addr_d  = in_address;
          data_d  = in_data;
        end
      end
      FULL: begin
        if (deliver) begin
          if (accept) begin
            addr_d = in_address;
            data_d = in_data;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  address_decoder u_dec (
    .en     (full),
    .addr   (addr_q),
    .onehot (out_valid)
  );

  assign out_data = data_q;

`ifdef DEMUX_COUNT_EN
  logic [COUNT_WIDTH-1:0] cnt_q [NUM_CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d [NUM_CHANNELS];

  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cnt_d[k] = cnt_q[k];
    end
    if (deliver) begin
      cnt_d[addr_q] = cnt_q[addr_q] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (reset) cnt_q[k] <= '0;
      else       cnt_q[k] <= cnt_d[k];
    end
  end

  // Reads the registered value, so a same-cycle deliver is not yet visible.
  assign count_out = cnt_q[count_sel];
`endif

endmodule
